// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: freezes the pipeline while a load/store runs.
// Optional MEMSTALL_READY_EN: handshake on dm_ready with a TIMEOUT watchdog.
module dmem_access_ctrl #(
    parameter int N       = 64,
    parameter int LATENCY = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] writeData,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic [N-1:0] dm_rdata,
    input  logic         dm_ready,
    output logic [N-1:0] readData,
    output logic         PC_enable,
    output logic         stall,
    output logic         protocol_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
        $error("dmem_access_ctrl: LATENCY must be in 1..15");
    end

    logic [1:0]   state_q, state_d;
    logic         dm_req_q, dm_req_d;
    logic         dm_we_q, dm_we_d;
    logic [N-1:0] dm_addr_q, dm_addr_d;
    logic [N-1:0] dm_wdata_q, dm_wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;
    logic         any_req;

    assign any_req = memRead | memWrite;

`ifdef MEMSTALL_READY_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    localparam int CW = $clog2(LATENCY + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_ready;
    assign unused_ready = dm_ready | (TIMEOUT < 0);
`endif

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
`ifdef MEMSTALL_READY_EN
        tmo_d      = tmo_q;
`else
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_ACCESS;
                    dm_req_d   = 1'b1;
                    dm_we_d    = memWrite;
                    dm_addr_d  = addr;
                    dm_wdata_d = writeData;
`ifdef MEMSTALL_READY_EN
                    tmo_d      = '0;
`else
                    cnt_d      = CW'(LATENCY - 1);
`endif
                    // Conflicting request resolves as a store
                    if (memRead && memWrite)
                        err_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!any_req)
                    err_d = 1'b1;
`ifdef MEMSTALL_READY_EN
                if (dm_ready) begin
                    if (!dm_we_q)
                        rdata_d = dm_rdata;
                    dm_req_d = 1'b0;
                    state_d  = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    dm_req_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`else
                if (cnt_q == '0) begin
                    if (!dm_we_q)
                        rdata_d = dm_rdata;
                    dm_req_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef MEMSTALL_READY_EN
            tmo_q      <= '0;
`else
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef MEMSTALL_READY_EN
            tmo_q      <= tmo_d;
`else
            cnt_q      <= cnt_d;
`endif
        end
    end

    // DONE releases the pipeline for exactly one cycle
    assign stall = ((state_q == S_IDLE) && any_req) || (state_q == S_ACCESS);
    assign PC_enable    = ~stall;
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign readData     = rdata_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected transactions queued by
// the stimulus, checked by a monitor when the DUT releases the pipeline.
module tb_dmem_access_ctrl;

    localparam int N   = 64;
    localparam int LAT = 2;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         memRead, memWrite;
    logic [N-1:0] addr, writeData;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
    logic         dm_ready;
    logic [N-1:0] readData;
    logic         PC_enable, stall, protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int           stall_n;
        int           req_n;
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] rdata;
        logic         err;
    } exp_t;

    exp_t exp_q[$];

    dmem_access_ctrl #(.N(N), .LATENCY(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .memRead(memRead), .memWrite(memWrite),
        .addr(addr), .writeData(writeData),
        .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .readData(readData), .PC_enable(PC_enable),
        .stall(stall), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a stall run ending without reset marks a DONE cycle
    int           stall_run = 0;
    int           req_run   = 0;
    logic         cap_we;
    logic [N-1:0] cap_addr, cap_wdata;

    always @(negedge clk) begin
        if (reset) begin
            stall_run = 0;
            req_run   = 0;
        end else begin
            if (dm_req) begin
                if (req_run == 0) begin
                    cap_we    = dm_we;
                    cap_addr  = dm_addr;
                    cap_wdata = dm_wdata;
                end
                req_run++;
            end
            if (stall) begin
                stall_run++;
            end else if (stall_run != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(stall_run), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stall_cycles", 64'(stall_run), 64'(e.stall_n));
                    chk("req_cycles", 64'(req_run), 64'(e.req_n));
                    chk("dm_we", 64'(cap_we), 64'(e.we));
                    chk("dm_addr", cap_addr, e.addr);
                    chk("dm_wdata", cap_wdata, e.wdata);
                    chk("readData", readData, e.rdata);
                    chk("protocol_err", 64'(protocol_err), 64'(e.err));
                    chk("pc_en_done", 64'(PC_enable), 64'd1);
                end
                stall_run = 0;
                req_run   = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE
    task automatic op(input logic rd, input logic wr,
                      input logic [N-1:0] a, input logic [N-1:0] wd,
                      input logic [N-1:0] rdv, input int hold,
                      input bit give_ready, input exp_t e);
        exp_q.push_back(e);
        memRead   = rd;
        memWrite  = wr;
        addr      = a;
        writeData = wd;
        dm_rdata  = rdv;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        dm_ready = give_ready;
        @(posedge clk); #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        dm_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic exp_t mk(input int s, input int r, input logic we,
                                input logic [N-1:0] a, input logic [N-1:0] wd,
                                input logic [N-1:0] rd, input logic err);
        exp_t e;
        e.stall_n = s;
        e.req_n   = r;
        e.we      = we;
        e.addr    = a;
        e.wdata   = wd;
        e.rdata   = rd;
        e.err     = err;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        addr      = '0;
        writeData = '0;
        dm_rdata  = '0;
        dm_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_stall", 64'(stall), 64'd0);
            chk("idle_pc_en", 64'(PC_enable), 64'd1);
            chk("idle_req", 64'(dm_req), 64'd0);
            chk("idle_rdata", readData, 64'd0);
            chk("idle_err", 64'(protocol_err), 64'd0);
        end
        @(posedge clk); #1;

        // Load, then store+load back-to-back
        op(1, 0, 64'h40, 64'h0, 64'hDEADBEEF, LAT, 1,
           mk(3, 2, 0, 64'h40, 64'h0, 64'hDEADBEEF, 0));
        op(0, 1, 64'h80, 64'h1234, 64'h5555, LAT, 1,
           mk(3, 2, 1, 64'h80, 64'h1234, 64'hDEADBEEF, 0));
        op(1, 0, 64'h80, 64'h0, 64'h1234, LAT, 1,
           mk(3, 2, 0, 64'h80, 64'h0, 64'h1234, 0));
        // Conflicting request: store issued, error sticky
        op(1, 1, 64'hC0, 64'hABCD, 64'h6666, LAT, 1,
           mk(3, 2, 1, 64'hC0, 64'hABCD, 64'h1234, 1));
        op(1, 0, 64'h100, 64'h0, 64'h77, LAT, 1,
           mk(3, 2, 0, 64'h100, 64'h0, 64'h77, 1));
        chk("err_sticky", 64'(protocol_err), 64'd1);

        // Reset pulsed in the first ACCESS cycle
        memRead  = 1'b1;
        addr     = 64'h200;
        dm_rdata = 64'h99;
        @(posedge clk); #1;
        reset   = 1'b1;
        memRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(dm_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_pc_en", 64'(PC_enable), 64'd1);
        chk("rst_rdata", readData, 64'd0);
        chk("rst_err", 64'(protocol_err), 64'd0);
        @(posedge clk); #1;

`ifdef MEMSTALL_READY_EN
        op(1, 0, 64'h300, 64'h0, 64'hCAFE, 4, 1,
           mk(5, 4, 0, 64'h300, 64'h0, 64'hCAFE, 0));
        op(1, 0, 64'h308, 64'h0, 64'hBEEF, TMO, 0,
           mk(TMO + 1, TMO, 0, 64'h308, 64'h0, 64'h0, 1));
`else
        op(1, 0, 64'h300, 64'h0, 64'hCAFE, LAT, 0,
           mk(3, 2, 0, 64'h300, 64'h0, 64'hCAFE, 0));
`endif

        repeat (4) @(posedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
